// File: rtl/seq_pattern_detector.sv
// seq_pattern_detector
//   Serial bit-pattern detector with a runtime-loadable pattern, overlapping
//   or non-overlapping match modes and a saturating match counter.
//
// Handshake: there is no back-pressure. A bit on ip is accepted in any
//   cycle where in_valid is high and pat_load is low. A pat_load cycle drops
//   the bit presented with it. Cycles with in_valid low leave the match
//   history untouched, so gaps in the stream are invisible to matching.
//
// Ports
//   clk         : clock, all state updates on the rising edge
//   rst         : synchronous active-high reset (wins over every other input)
//   ip          : serial data bit
//   in_valid    : ip is accepted this cycle when high
//   pat         : new pattern, MSB is the oldest bit to match
//   pat_load    : load pat into pat_q and flush the history
//   overlap_en  : 1 = overlapping matches, 0 = non-overlapping
//   cnt_clr     : clear match_count (a same-cycle hit still counts as 1)
//   op          : Mealy match, combinational, same cycle as the completing bit
//   opm         : Moore match, registered copy of op
//   match_count : saturating number of matches
//   pat_q       : active pattern
module seq_pattern_detector #(
  parameter int              PAT_W   = 4,
  parameter int              CNT_W   = 8,
  parameter logic [PAT_W-1:0] PAT_RST = 4'b1010
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ip,
  input  logic             in_valid,
  input  logic [PAT_W-1:0] pat,
  input  logic             pat_load,
  input  logic             overlap_en,
  input  logic             cnt_clr,
  output logic             op,
  output logic             opm,
  output logic [CNT_W-1:0] match_count,
  output logic [PAT_W-1:0] pat_q
);

  // fill counts 0..PAT_W, so it needs enough bits to hold PAT_W itself.
  localparam int FW = $clog2(PAT_W + 1);
  localparam logic [FW-1:0]    FILL_MAX = FW'(PAT_W);
  localparam logic [FW-1:0]    FILL_MIN = FW'(PAT_W - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  // Only the newest PAT_W-1 history bits are ever looked at: the oldest
  // bit of the previous window falls off as soon as the next bit arrives,
  // so it is not stored.
  logic [PAT_W-2:0] hist;
  logic [FW-1:0]    fill;
  logic [PAT_W-1:0] window;
  logic             accept;
  logic             hit;

  assign accept = in_valid & ~pat_load;
  assign window = {hist, ip};

  // fill >= PAT_W-1 means the history plus the current bit make a full
  // window of bits that all arrived after the last flush.
  assign hit = accept & ~rst & (fill >= FILL_MIN) & (window == pat_q);
  assign op  = hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      hist        <= '0;
      fill        <= '0;
      pat_q       <= PAT_RST;
      opm         <= 1'b0;
      match_count <= '0;
    end else begin
      opm <= hit;

      if (cnt_clr) begin
        match_count <= hit ? CNT_W'(1) : '0;
      end else if (hit && (match_count != CNT_MAX)) begin
        match_count <= match_count + CNT_W'(1);
      end

      if (pat_load) begin
        pat_q <= pat;
        hist  <= '0;
        fill  <= '0;
      end else if (in_valid) begin
        hist <= window[PAT_W-2:0];
        // Non-overlapping mode restarts the fill so the next match must be
        // built entirely from fresh bits.
        if (hit && !overlap_en) begin
          fill <= '0;
        end else if (fill != FILL_MAX) begin
          fill <= fill + FW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_pattern_detector.sv
// tb_seq_pattern_detector
//   Directed-vector bench for seq_pattern_detector (PAT_W=4, CNT_W=2).
//   Each cycle the bench drives inputs on the falling edge, checks op a
//   moment later, and checks opm against the op expected one cycle earlier.
module tb_seq_pattern_detector;

  localparam int PAT_W = 4;
  localparam int CNT_W = 2;

  // ---------------- clock / reset ----------------
  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             ip = 1'b0;
  logic             in_valid = 1'b0;
  logic [PAT_W-1:0] pat = '0;
  logic             pat_load = 1'b0;
  logic             overlap_en = 1'b1;
  logic             cnt_clr = 1'b0;
  logic             op;
  logic             opm;
  logic [CNT_W-1:0] match_count;
  logic [PAT_W-1:0] pat_q;

  always #5 clk = ~clk;

  seq_pattern_detector #(
    .PAT_W   (PAT_W),
    .CNT_W   (CNT_W),
    .PAT_RST (4'b1010)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ip          (ip),
    .in_valid    (in_valid),
    .pat         (pat),
    .pat_load    (pat_load),
    .overlap_en  (overlap_en),
    .cnt_clr     (cnt_clr),
    .op          (op),
    .opm         (opm),
    .match_count (match_count),
    .pat_q       (pat_q)
  );

  // ---------------- scoreboard ----------------
  int   n_checks = 0;
  int   n_errors = 0;
  logic prev_exp_op = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  // One clock cycle: drive inputs, check op and opm, let the edge happen.
  task automatic cycle(input logic r, input logic v, input logic b, input logic pl,
                       input logic [PAT_W-1:0] pt, input logic clr,
                       input logic exp_op, input string tag);
    @(negedge clk);
    rst      = r;
    in_valid = v;
    ip       = b;
    pat_load = pl;
    pat      = pt;
    cnt_clr  = clr;
    #1;
    check({tag, ".op"}, 32'(op), 32'(exp_op));
    check({tag, ".opm"}, 32'(opm), 32'(prev_exp_op));
    prev_exp_op = exp_op;
  endtask

  task automatic idle(input string tag);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, tag);
  endtask

  // Load a pattern and clear the counter in one cycle.
  task automatic load(input logic [PAT_W-1:0] pt, input string tag);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, pt, 1'b1, 1'b0, tag);
  endtask

  // Feed n valid bits, oldest first from bits[n-1]; hits[] marks the bits
  // expected to complete a match.
  task automatic feed(input logic [15:0] bits, input int n, input logic [15:0] hits,
                      input string tag);
    for (int i = n - 1; i >= 0; i--) begin
      cycle(1'b0, 1'b1, bits[i], 1'b0, '0, 1'b0, hits[i], tag);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset state; op must stay low while rst is high.
    cycle(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, "rst");
    idle("rst_idle");
    check("rst.pat_q", 32'(pat_q), 32'hA);
    check("rst.count", 32'(match_count), 32'd0);

    // Overlapping: 1,0,1,0,1,0 -> hits on bits 4 and 6.
    overlap_en = 1'b1;
    feed(16'b101010, 6, 16'b000101, "ovl");
    idle("ovl_tail");
    check("ovl.count", 32'(match_count), 32'd2);

    // Non-overlapping: 1,0,1,0,1,0,1,0 -> hits on bits 4 and 8 only.
    load(4'b1010, "load_nov");
    overlap_en = 1'b0;
    feed(16'b10101010, 8, 16'b00010001, "nov");
    idle("nov_tail");
    check("nov.count", 32'(match_count), 32'd2);

    // Valid gaps are transparent; ip toggling during the gap is ignored.
    load(4'b1010, "load_gap");
    overlap_en = 1'b1;
    feed(16'b10, 2, 16'b00, "gap_a");
    cycle(1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0, "gap");
    cycle(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, "gap");
    cycle(1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0, "gap");
    feed(16'b10, 2, 16'b01, "gap_b");
    idle("gap_tail");
    check("gap.count", 32'(match_count), 32'd1);

    // Pattern reload flushes history: next bit 1 cannot match, then
    // 1,1,0,1 matches on its 4th bit.
    feed(16'b110, 3, 16'b000, "rl_pre");
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 4'b1101, 1'b0, 1'b0, "rl_load");
    feed(16'b1, 1, 16'b0, "rl_next");
    feed(16'b1101, 4, 16'b0001, "rl_strm");
    idle("rl_tail");
    check("rl.pat_q", 32'(pat_q), 32'hD);
    check("rl.count", 32'(match_count), 32'd2);

    // Saturation with CNT_W=2: five overlapping matches of 1101 -> 3.
    load(4'b1101, "load_sat");
    feed(16'b1101101101101101, 16, 16'b0001001001001001, "sat");
    idle("sat_tail");
    check("sat.count", 32'(match_count), 32'd3);

    // cnt_clr coincident with a hit leaves the count at 1.
    cycle(1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b0, "clr_a");
    cycle(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, "clr_b");
    cycle(1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b1, 1'b1, "clr_hit");
    idle("clr_tail");
    check("clr.count", 32'(match_count), 32'd1);

    // in_valid with pat_load drops the bit: the window would read 1101
    // but no hit may occur.
    feed(16'b10, 2, 16'b00, "drop_pre");
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 4'b1101, 1'b0, 1'b0, "drop");
    idle("drop_tail");
    check("drop.count", 32'(match_count), 32'd1);
    check("drop.pat_q", 32'(pat_q), 32'hD);

    // Mid-stream reset: 1,0,1 then reset with a bit that would complete
    // 1010, then bit 0 -> no op anywhere.
    load(4'b1010, "load_mrst");
    feed(16'b101, 3, 16'b000, "mrst_pre");
    cycle(1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, "mrst_rst");
    feed(16'b0, 1, 16'b0, "mrst_post");
    idle("mrst_tail");
    check("mrst.pat_q", 32'(pat_q), 32'hA);
    check("mrst.count", 32'(match_count), 32'd0);
    feed(16'b1010, 4, 16'b0001, "mrst_strm");
    idle("mrst_tail2");
    check("mrst.count2", 32'(match_count), 32'd1);

    // Reset beats pat_load and in_valid in the same cycle.
    cycle(1'b1, 1'b1, 1'b0, 1'b1, 4'b0110, 1'b0, 1'b0, "prio");
    idle("prio_tail");
    check("prio.pat_q", 32'(pat_q), 32'hA);
    check("prio.count", 32'(match_count), 32'd0);

    // ---------------- final report ----------------
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
